// File: rtl/cdc_pkg.sv
// Shared constants for clock-domain-crossing blocks.
package cdc_pkg;

    localparam int unsigned MIN_SYNC_STAGES = 2;
    localparam int unsigned MAX_SYNC_STAGES = 4;

    // Encodings for the enable interpretation of data_sync_enable.
    localparam int unsigned MODE_LEVEL  = 0;
    localparam int unsigned MODE_TOGGLE = 1;

endpackage : cdc_pkg

// File: rtl/sync_chain.sv
// STAGE_COUNT-deep single-bit synchronizer chain, async active-low reset.
module sync_chain #(
    parameter int unsigned STAGE_COUNT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGE_COUNT-1:0] stages;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stages <= '0;
        end else begin
            stages <= {stages[STAGE_COUNT-2:0], d};
        end
    end

    assign q = stages[STAGE_COUNT-1];

endmodule : sync_chain

// File: rtl/data_sync_enable.sv
// Bus synchronizer: only the enable crosses through a flop chain; the bus is
// captured once on the synchronized enable event.
module data_sync_enable
    import cdc_pkg::*;
#(
    parameter int unsigned          STAGE_COUNT = 2,
    parameter int unsigned          BUS_WIDTH   = 8,
    parameter int unsigned          TOGGLE_MODE = MODE_LEVEL,
    parameter logic [BUS_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    input  logic                 bus_enable,
    output logic [BUS_WIDTH-1:0] sync_bus,
    output logic                 enable_pulse,
    output logic [7:0]           transfer_count
);

    localparam int unsigned COUNT_WIDTH = 8;

    if (STAGE_COUNT < MIN_SYNC_STAGES || STAGE_COUNT > MAX_SYNC_STAGES) begin : g_stage_check
        $error("data_sync_enable: STAGE_COUNT out of range");
    end

    logic sync_en;
    logic prev_en;
    logic event_c;

    sync_chain #(
        .STAGE_COUNT(STAGE_COUNT)
    ) u_enable_sync (
        .clk  (clk),
        .reset(reset),
        .d    (bus_enable),
        .q    (sync_en)
    );

    // Level mode reacts to rising edges only; toggle mode to any change.
    always_comb begin
        event_c = 1'b0;
        if (TOGGLE_MODE == MODE_TOGGLE) begin
            event_c = sync_en ^ prev_en;
        end else begin
            event_c = sync_en & ~prev_en;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_en        <= 1'b0;
            sync_bus       <= RESET_VALUE;
            enable_pulse   <= 1'b0;
            transfer_count <= '0;
        end else begin
            prev_en      <= sync_en;
            enable_pulse <= event_c;
            if (event_c) begin
                sync_bus       <= unsync_bus;
                transfer_count <= transfer_count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule : data_sync_enable
